// File: rtl/my_fifo4x16.sv
// rtl/my_fifo4x16.sv - 4-entry x 16-bit show-ahead FIFO whose head word is selected by my_mux4way16
// The read pointer selects one of the four storage registers, so the head word is available with no read latency.

module my_mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = a;
    unique case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end
endmodule

module my_fifo4x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count,
  output logic        overflow,
  output logic        underflow
);
  logic [15:0] r0, r1, r2, r3;
  logic [1:0]  wr_ptr, rd_ptr;
  logic        pop_ok, push_ok;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);

  // Accept a push into a full FIFO only when a pop frees the head slot on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  my_mux4way16 u_mux (
    .a   (r0),
    .b   (r1),
    .c   (r2),
    .d   (r3),
    .sel (rd_ptr),
    .out (out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0        <= 16'h0000;
      r1        <= 16'h0000;
      r2        <= 16'h0000;
      r3        <= 16'h0000;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        unique case (wr_ptr)
          2'd0: r0 <= in;
          2'd1: r1 <= in;
          2'd2: r2 <= in;
          2'd3: r3 <= in;
          default: r0 <= in;
        endcase
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count     <= count + 3'(push_ok) - 3'(pop_ok);
      overflow  <= push & ~push_ok;
      underflow <= pop & ~pop_ok;
    end
  end
endmodule

// File: tb/tb_my_fifo4x16.sv
// tb/tb_my_fifo4x16.sv - directed self-checking bench for my_fifo4x16
// Inputs change 1 ns after each rising edge; outputs are sampled in the same quiet window.

module tb_my_fifo4x16;
  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        push;
  logic        pop;
  logic [15:0] out;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [15:0] w [6];

  my_fifo4x16 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .push      (push),
    .pop       (pop),
    .out       (out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [15:0] d);
    push = p;
    pop  = q;
    in   = d;
    step();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in    = 16'h0000;
    push  = 1'b0;
    pop   = 1'b0;
    step();
    step();
    check("rst_count", 16'(count), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full", 16'(full), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_udf", 16'(underflow), 16'd0);
    check("rst_out", out, 16'h0000);
    reset = 1'b0;
    step();

    // 1: fill
    drive(1, 0, 16'b0101010101010101);
    drive(1, 0, 16'b1010101010101010);
    drive(1, 0, 16'b0000000011111111);
    drive(1, 0, 16'b1111111100000000);
    check("t1_full", 16'(full), 16'd1);
    check("t1_count", 16'(count), 16'd4);
    check("t1_out", out, 16'b0101010101010101);

    // 2: drain
    drive(0, 1, 16'h0000);
    check("t2_out1", out, 16'b1010101010101010);
    drive(0, 1, 16'h0000);
    check("t2_out2", out, 16'b0000000011111111);
    drive(0, 1, 16'h0000);
    check("t2_out3", out, 16'b1111111100000000);
    drive(0, 1, 16'h0000);
    check("t2_empty", 16'(empty), 16'd1);
    check("t2_count", 16'(count), 16'd0);
    check("t2_rdptr", 16'(dut.rd_ptr), 16'd0);

    // 3: overflow, then push+pop while full
    drive(1, 0, 16'h1111);
    drive(1, 0, 16'h2222);
    drive(1, 0, 16'h3333);
    drive(1, 0, 16'h4444);
    drive(1, 0, 16'hAAAA);
    check("t3_ovf", 16'(overflow), 16'd1);
    check("t3_count", 16'(count), 16'd4);
    check("t3_out", out, 16'h1111);
    step();
    check("t3_ovf_clr", 16'(overflow), 16'd0);
    drive(1, 1, 16'h1234);
    check("t3_pp_count", 16'(count), 16'd4);
    check("t3_pp_out", out, 16'h2222);
    drive(0, 1, 16'h0000);
    check("t3_pop1", out, 16'h3333);
    drive(0, 1, 16'h0000);
    check("t3_pop2", out, 16'h4444);
    drive(0, 1, 16'h0000);
    check("t3_head", out, 16'h1234);
    check("t3_count1", 16'(count), 16'd1);
    drive(0, 1, 16'h0000);
    check("t3_empty", 16'(empty), 16'd1);

    // 4: underflow
    drive(0, 1, 16'h0000);
    check("t4_udf", 16'(underflow), 16'd1);
    check("t4_count", 16'(count), 16'd0);
    step();
    check("t4_udf_clr", 16'(underflow), 16'd0);
    drive(1, 1, 16'h00FF);
    check("t4_pp_udf", 16'(underflow), 16'd1);
    check("t4_pp_count", 16'(count), 16'd1);
    check("t4_pp_out", out, 16'h00FF);
    drive(0, 1, 16'h0000);
    check("t4_empty", 16'(empty), 16'd1);

    // 5: pointer wrap with occupancy kept at 1..2
    for (int i = 0; i < 6; i++) w[i] = 16'hC000 + 16'(i * 16'h0111);
    drive(1, 0, w[0]);
    for (int i = 1; i < 6; i++) begin
      check($sformatf("t5_out%0d", i - 1), out, w[i - 1]);
      push = 1'b1;
      in   = w[i];
      step();
      push = 1'b0;
      check($sformatf("t5_cnt%0d", i), 16'(count), 16'd2);
      pop = 1'b1;
      step();
      pop = 1'b0;
      check($sformatf("t5_cntp%0d", i), 16'(count), 16'd1);
    end
    check("t5_out5", out, w[5]);
    drive(0, 1, 16'h0000);
    check("t5_empty", 16'(empty), 16'd1);

    // 6: async reset between edges
    drive(1, 0, 16'h0A0A);
    drive(1, 0, 16'h0B0B);
    drive(1, 0, 16'h0C0C);
    check("t6_count3", 16'(count), 16'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_count", 16'(count), 16'd0);
    check("t6_rst_empty", 16'(empty), 16'd1);
    check("t6_rst_out", out, 16'h0000);
    step();
    reset = 1'b0;
    drive(1, 0, 16'h5A5A);
    check("t6_out", out, 16'h5A5A);
    check("t6_count", 16'(count), 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
